matrix_result_streamer: RTL
===========================

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 SHALL have parameter ELEM_W, default 8: bit width of one matrix element (signed two's complement).
REQ-002 SHALL have parameter N_ELEM, default 25: elements per matrix (5x5, row-major).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to capture and stream one result matrix.
REQ-006 SHALL have port MatIn  input  ELEM_W*N_ELEM (200)  flat result matrix; element k = MatIn[ELEM_W*k+ELEM_W-1 : ELEM_W*k].
REQ-007 SHALL have port OverflowIn  input  1  overflow flag accompanying MatIn.
REQ-008 SHALL have port out_data  output  ELEM_W  current element.
REQ-009 SHALL have port out_index  output  5  index k of current element (0..N_ELEM-1).
REQ-010 SHALL have port out_valid  output  1  out_data/out_index/out_last valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the current element.
REQ-012 SHALL have port out_last  output  1  high with the element k = N_ELEM-1.
REQ-013 SHALL have port busy  output  1  streaming in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse after final transfer.
REQ-015 SHALL have port overflow  output  1  OverflowIn latched at capture.

Function
REQ-016 SHALL implement states IDLE and SEND; busy = (state == SEND).
REQ-017 In IDLE, start=1 at a rising edge SHALL copy MatIn into an internal shadow register, latch OverflowIn into overflow, clear the index to 0, and enter SEND.
REQ-018 out_valid SHALL assert in the cycle after start is sampled (latency 1) and remain high throughout SEND.
REQ-019 SHALL drive out_data from the shadow register element at out_index; out_data SHALL never change from MatIn changes after capture.
REQ-020 A transfer SHALL occur at a rising edge where out_valid=1 and out_ready=1; the index SHALL then advance by 1.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable.
REQ-022 With out_ready held high, SHALL transfer one element per cycle; all N_ELEM elements SHALL take exactly N_ELEM cycles.
REQ-023 out_last SHALL be high only when out_valid=1 and out_index = N_ELEM-1.
REQ-024 On the transfer of the last element, SHALL return to IDLE; in the next cycle out_valid=0, busy=0 and done=1 for exactly one cycle.
REQ-025 start SHALL be ignored while busy=1, including the cycle of the last transfer; shadow register and overflow SHALL not change.
REQ-026 start sampled in the cycle done=1 (state IDLE) SHALL be accepted normally.
REQ-027 overflow SHALL hold its latched value until the next accepted start or reset.
REQ-028 out_ready while out_valid=0 SHALL have no effect.
REQ-029 out_index SHALL never exceed N_ELEM-1; no wrap-around within a matrix.

Reset
REQ-030 reset=1 at a rising edge SHALL force state IDLE, index 0, out_valid=0, out_last=0, busy=0, done=0, overflow=0, out_data=0.
REQ-031 reset SHALL take priority over start and over any transfer in the same cycle.
REQ-032 reset during SEND SHALL abandon the matrix; no further elements and no done pulse SHALL be produced.

Verification
REQ-033 MatIn element k = k+1 (k=0..24), OverflowIn=0, start pulse, out_ready=1 -> out_valid at start+1, out_data 1..25 on 25 consecutive cycles, out_last with 25, done one cycle later, overflow=0.
REQ-034 Same matrix, out_ready toggling 1,0,1,0... -> each element held while ready=0, order 1..25 intact, 25 transfers total in 49 cycles.
REQ-035 Capture with element 3 = 8'h80, OverflowIn=1, then change MatIn to all 8'hFF during SEND -> out_index 3 yields 8'h80, no FF emitted, overflow=1 throughout and after done.
REQ-036 Second start asserted at index 10 of a stream -> ignored; stream continues 11..25; start in done cycle -> new stream begins next cycle at index 0.
REQ-037 reset asserted at index 7 with out_ready=1 -> next cycle out_valid=0, busy=0, done=0, overflow=0; no element 8 emitted.

Source files
------------

// File: rtl/matrix_result_streamer.sv
// Matrix result streamer: captures a flat result matrix into a shadow
// register on start and streams it out one element per valid/ready
// handshake, with a one-cycle done pulse after the final element.
module matrix_result_streamer #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 25
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ELEM_W*N_ELEM-1:0]   MatIn,
  input  logic                       OverflowIn,
  output logic [ELEM_W-1:0]          out_data,
  output logic [4:0]                 out_index,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);

  state_t                     stateR;
  logic [ELEM_W*N_ELEM-1:0]   shadowR;
  logic [4:0]                 indexR;
  logic [ELEM_W-1:0]          dataR;
  logic                       validR;
  logic                       lastR;
  logic                       busyR;
  logic                       doneR;
  logic                       overflowR;

  logic [4:0]                 nextIdx;
  logic [4:0]                 selIdx;
  logic [ELEM_W-1:0]          nextElem;

  // Pick the element that follows the current one; the select is clamped on
  // the last element so the part-select never leaves the shadow register.
  always_comb begin
    nextIdx = indexR + 5'd1;
    if (indexR == LAST_IDX) begin
      selIdx = indexR;
    end else begin
      selIdx = nextIdx;
    end
    nextElem = shadowR[ELEM_W*int'(selIdx) +: ELEM_W];
  end

  // Capture/stream state machine; every output is a register so the
  // handshake outputs hold exactly while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR    <= IDLE;
      shadowR   <= '0;
      indexR    <= 5'd0;
      dataR     <= '0;
      validR    <= 1'b0;
      lastR     <= 1'b0;
      busyR     <= 1'b0;
      doneR     <= 1'b0;
      overflowR <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (stateR)
        IDLE: begin
          if (start) begin
            shadowR   <= MatIn;
            overflowR <= OverflowIn;
            indexR    <= 5'd0;
            dataR     <= MatIn[ELEM_W-1:0];
            validR    <= 1'b1;
            lastR     <= (LAST_IDX == 5'd0);
            busyR     <= 1'b1;
            stateR    <= SEND;
          end else begin
            validR <= 1'b0;
            lastR  <= 1'b0;
            busyR  <= 1'b0;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (indexR == LAST_IDX) begin
              validR <= 1'b0;
              lastR  <= 1'b0;
              busyR  <= 1'b0;
              doneR  <= 1'b1;
              stateR <= IDLE;
            end else begin
              indexR <= nextIdx;
              dataR  <= nextElem;
              lastR  <= (nextIdx == LAST_IDX);
            end
          end else begin
            indexR <= indexR;
          end
        end
        default: begin
          validR <= 1'b0;
          lastR  <= 1'b0;
          busyR  <= 1'b0;
          stateR <= IDLE;
        end
      endcase
    end
  end

  assign out_data  = dataR;
  assign out_index = indexR;
  assign out_valid = validR;
  assign out_last  = lastR;
  assign busy      = busyR;
  assign done      = doneR;
  assign overflow  = overflowR;

endmodule
